// File: rtl/servo_pkg.sv
// servo_pkg: ramp state type, default servo timing constants and the target clamp
// shared by servo_ramp and its frame timer.
package servo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  localparam int unsigned CLK_HZ       = 100000000;
  localparam int unsigned SERVO_T_20MS = 2000000;
  localparam int unsigned SERVO_D_1MS  = 100000;
  localparam int unsigned SERVO_D_2MS  = 200000;

  function automatic logic [31:0] clamp(input logic [31:0] v,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    logic [31:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// servo_frame_timer: free-running frame counter 0..T_PERIOD-1 with a one-cycle
// combinational frame_tick on the last count; enable low freezes it.
module servo_frame_timer #(
  parameter int unsigned T_PERIOD = 2000000
) (
  input  logic clk,
  input  logic res,
  input  logic enable,
  output logic frame_tick
);

  localparam int unsigned CW = (T_PERIOD > 1) ? $clog2(T_PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    frame_tick = enable && (cnt_q == CW'(T_PERIOD - 1));
    cnt_d      = cnt_q;
    if (frame_tick) cnt_d = '0;
    else if (enable) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (res) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/servo_ramp.sv
// servo_ramp: slews the PWM pulse width d toward a clamped command target, one
// bounded step per frame. Define SERVO_RAMP_IRQ_EN to add the irq/irq_ack pair.
//
// state | meaning
// IDLE  | no ramp active, commands accepted (cmd_ready=1)
// RAMP  | stepping d toward target_q on each frame_tick
module servo_ramp
  import servo_pkg::*;
#(
  parameter int unsigned T_PERIOD = SERVO_T_20MS,
  parameter int unsigned D_MIN    = SERVO_D_1MS,
  parameter int unsigned D_MAX    = SERVO_D_2MS,
  parameter int unsigned D_INIT   = 150000
) (
  input  logic        clk,
  input  logic        res,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_target,
  input  logic [31:0] cmd_step,
  output logic [31:0] d,
  output logic [31:0] t,
  output logic        frame_tick,
  output logic        busy,
  output logic        done
`ifdef SERVO_RAMP_IRQ_EN
  ,
  input  logic        irq_ack,
  output logic        irq
`endif
);

  state_e      state_q, state_d;
  logic [31:0] d_q, d_d;
  logic [31:0] target_q, target_d;
  logic [31:0] step_q, step_d;
  logic        done_q, done_d;
  logic [31:0] tgt_clamped;
  logic [32:0] diff;

  servo_frame_timer #(.T_PERIOD(T_PERIOD)) u_timer (
    .clk       (clk),
    .res       (res),
    .enable    (enable),
    .frame_tick(frame_tick)
  );

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    target_d    = target_q;
    step_d      = step_q;
    done_d      = 1'b0;
    tgt_clamped = clamp(cmd_target, 32'(D_MIN), 32'(D_MAX));
    // 33-bit magnitude so the step compare can never wrap
    if (target_q >= d_q) diff = {1'b0, target_q} - {1'b0, d_q};
    else                 diff = {1'b0, d_q} - {1'b0, target_q};

    if (state_q == IDLE) begin
      if (cmd_valid) begin
        target_d = tgt_clamped;
        step_d   = (cmd_step == 32'd0) ? 32'd1 : cmd_step;
        if (tgt_clamped == d_q) done_d  = 1'b1;
        else                    state_d = RAMP;
      end
    end else if (frame_tick) begin
      if (diff <= {1'b0, step_q}) begin
        d_d     = target_q;
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (target_q > d_q) begin
        d_d = d_q + step_q;
      end else begin
        d_d = d_q - step_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      d_q      <= 32'(D_INIT);
      target_q <= 32'(D_INIT);
      step_q   <= 32'd1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      target_q <= target_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  assign d         = d_q;
  assign t         = 32'(T_PERIOD);
  assign done      = done_q;
  assign busy      = (state_q == RAMP);
  assign cmd_ready = (state_q == IDLE);

`ifdef SERVO_RAMP_IRQ_EN
  logic irq_q, irq_d;

  // set dominates a simultaneous ack so no completion is lost
  always_comb begin
    irq_d = irq_q;
    if (irq_ack) irq_d = 1'b0;
    if (done_d)  irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (res) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule
